// File: rtl/spi_responder_if.sv
// SPI pin bundle between a mode-0 master and the spi_responder target.
interface spi_responder_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output cs_n, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input cs_n, output miso, output miso_oe);
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 target that oversamples sclk/mosi/cs_n on the system clock; one byte in, one byte out per frame.
// Optional sticky overrun flag is built when SPI_RESPONDER_OVERRUN_EN is defined.
module spi_responder #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_responder_if.slave   spi,
    input  logic [7:0]       tx_data,
    input  logic             tx_wr,
    output logic             tx_pending,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE, SEL} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, cs_pipe;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_fall;
    logic                   enter, active, do_rise, do_fall, byte_done, reload;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             holding;
    logic                   reload_armed;

    // Input synchronizers plus one edge-detect flop on sclk and cs_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pipe <= '0;
            mosi_pipe <= '0;
            cs_pipe   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi.sclk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi.mosi};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi.cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign cs_s      = cs_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nxt = SEL;
                enter     = 1'b1;
            end
            SEL:  if (cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The deselect cycle itself (state still SEL, cs already high) ignores sclk
    assign active    = (state == SEL) && !cs_s;
    assign do_rise   = active && sclk_rise;
    assign do_fall   = active && sclk_fall;
    assign byte_done = do_rise && (bit_cnt == 3'd7);
    assign reload    = enter || (do_fall && (bit_cnt == 3'd0) && reload_armed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= 3'd0;
            rx_shift     <= 7'd0;
            reload_armed <= 1'b0;
        end else if ((state == SEL) && cs_s) begin
            bit_cnt      <= 3'd0;
            rx_shift     <= 7'd0;
            reload_armed <= 1'b0;
        end else if (do_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= {rx_shift[5:0], mosi_s};
            if (bit_cnt == 3'd7) reload_armed <= 1'b1;
        end else if (reload) begin
            reload_armed <= 1'b0;
        end
    end

    // Reload reads the pre-write holding value, so a same-cycle tx_wr stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= FILL_BYTE;
            holding    <= 8'h00;
            tx_pending <= 1'b0;
        end else begin
            if (reload)
                tx_shift <= tx_pending ? holding : FILL_BYTE;
            else if (do_fall && (bit_cnt != 3'd0))
                tx_shift <= {tx_shift[6:0], 1'b1};
            if (tx_wr) begin
                holding    <= tx_data;
                tx_pending <= 1'b1;
            end else if (reload) begin
                tx_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (byte_done) begin
            rx_data  <= {rx_shift, mosi_s};
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_RESPONDER_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (byte_done && rx_valid && !rx_ack)
            overrun <= 1'b1;
        else if (rx_ack)
            overrun <= 1'b0;
    end
`else
    assign overrun = 1'b0;
`endif

    assign spi.miso    = tx_shift[7];
    assign spi.miso_oe = (state == SEL);
    assign busy        = (bit_cnt != 3'd0) && (state == SEL);

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: bit-banged mode-0 master with hand-computed expectations.
module tb_spi_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_pending;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;
    logic       busy;
    int         errors;
    int         checks;
    logic [7:0] got, got2;
    logic       ovr_exp;

    spi_responder_if bus ();

    spi_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (bus.slave),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_pending (tx_pending),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift nbits MSB-first; miso sampled just before each rise; optional tx_wr during the first bit
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit wr,
                            input logic [7:0] wbyte, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            if (wr && i == 7) begin
                tick(2);
                tx_data = wbyte;
                tx_wr   = 1'b1;
                tick(1);
                tx_wr   = 1'b0;
                tick(2);
            end else begin
                tick(5);
            end
            rd[i]    = bus.miso;
            bus.sclk = 1'b1;
            tick(5);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic deselect();
        tick(5);
        bus.cs_n = 1'b1;
        tick(6);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
`ifdef SPI_RESPONDER_OVERRUN_EN
        ovr_exp = 1'b1;
`else
        ovr_exp = 1'b0;
`endif
        rst_n    = 1'b0;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        tx_data  = 8'h00;
        tx_wr    = 1'b0;
        rx_ack   = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        check("reset_miso", {7'd0, bus.miso}, 8'h01);
        check("reset_oe", {7'd0, bus.miso_oe}, 8'h00);
        check("reset_pending", {7'd0, tx_pending}, 8'h00);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("reset_overrun", {7'd0, overrun}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);

        // A5 in, nothing pending -> FF out; rx_valid appears SYNC_STAGES+1 clk after the 8th rise
        bus.cs_n = 1'b0;
        spi_bits(8'hA5, 7, 1'b0, 8'h00, got);
        check("sel_oe", {7'd0, bus.miso_oe}, 8'h01);
        bus.mosi = 1'b1;
        tick(5);
        got[0]   = bus.miso;
        bus.sclk = 1'b1;
        tick(2);
        check("rx_valid_early", {7'd0, rx_valid}, 8'h00);
        tick(1);
        check("rx_valid_latency", {7'd0, rx_valid}, 8'h01);
        check("rx_data_a5", rx_data, 8'hA5);
        tick(2);
        bus.sclk = 1'b0;
        check("miso_fill", got, 8'hFF);
        deselect();
        check("idle_oe", {7'd0, bus.miso_oe}, 8'h00);
        ack();
        check("ack_clears", {7'd0, rx_valid}, 8'h00);

        // Pending byte is loaded at the cs_n fall
        tx_data = 8'h3C;
        tx_wr   = 1'b1;
        tick(1);
        tx_wr   = 1'b0;
        check("pending_set", {7'd0, tx_pending}, 8'h01);
        bus.cs_n = 1'b0;
        tick(2);
        check("pending_before_load", {7'd0, tx_pending}, 8'h01);
        tick(1);
        check("pending_consumed", {7'd0, tx_pending}, 8'h00);
        spi_bits(8'h00, 8, 1'b0, 8'h00, got);
        check("miso_3c", got, 8'h3C);
        tick(3);
        check("rx_data_00", rx_data, 8'h00);
        deselect();
        ack();

        // Back-to-back 12,34 with tx_wr 56 during the first byte
        bus.cs_n = 1'b0;
        spi_bits(8'h12, 8, 1'b1, 8'h56, got);
        spi_bits(8'h34, 8, 1'b0, 8'h00, got2);
        tick(3);
        check("b2b_first_read", got, 8'hFF);
        check("b2b_second_read", got2, 8'h56);
        check("b2b_rx_data", rx_data, 8'h34);
        check("b2b_pending", {7'd0, tx_pending}, 8'h00);
        deselect();
        ack();

        // Two bytes without rx_ack
        bus.cs_n = 1'b0;
        spi_bits(8'h11, 8, 1'b0, 8'h00, got);
        spi_bits(8'h22, 8, 1'b0, 8'h00, got);
        tick(3);
        check("ovr_flag", {7'd0, overrun}, {7'd0, ovr_exp});
        check("ovr_rx_data", rx_data, 8'h22);
        check("ovr_rx_valid", {7'd0, rx_valid}, 8'h01);
        deselect();
        ack();
        check("ovr_ack_valid", {7'd0, rx_valid}, 8'h00);
        check("ovr_ack_flag", {7'd0, overrun}, 8'h00);

        // Partial frame of 5 bits, then a full 81
        bus.cs_n = 1'b0;
        spi_bits(8'hF0, 5, 1'b0, 8'h00, got);
        tick(3);
        check("partial_busy", {7'd0, busy}, 8'h01);
        bus.cs_n = 1'b1;
        tick(3);
        check("partial_busy_clr", {7'd0, busy}, 8'h00);
        tick(4);
        check("partial_no_valid", {7'd0, rx_valid}, 8'h00);
        bus.cs_n = 1'b0;
        spi_bits(8'h81, 8, 1'b0, 8'h00, got);
        tick(3);
        check("full_rx_data", rx_data, 8'h81);
        check("full_rx_valid", {7'd0, rx_valid}, 8'h01);
        check("full_busy", {7'd0, busy}, 8'h00);
        check("full_read_fill", got, 8'hFF);
        deselect();

        // Async reset mid-byte with a pending tx byte
        bus.cs_n = 1'b0;
        spi_bits(8'hC3, 3, 1'b1, 8'hAA, got);
        tick(3);
        check("pre_rst_pending", {7'd0, tx_pending}, 8'h01);
        check("pre_rst_busy", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("rst_miso", {7'd0, bus.miso}, 8'h01);
        check("rst_oe", {7'd0, bus.miso_oe}, 8'h00);
        check("rst_pending", {7'd0, tx_pending}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_overrun", {7'd0, overrun}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        bus.cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        bus.cs_n = 1'b0;
        spi_bits(8'h5A, 8, 1'b0, 8'h00, got);
        tick(3);
        check("post_rst_fill", got, 8'hFF);
        check("post_rst_rx", rx_data, 8'h5A);
        deselect();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
